dct_whole: RTL and testbench

DCT_WHOLE -- requirements
Module: dct_whole

---
 rtl/dct_pkg.sv | 25 ++
 rtl/dct_1d_4pt.sv | 35 +++
 rtl/dct_whole.sv | 119 +++++++++++
 tb/tb_dct_whole.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants for the 4x4 forward/inverse integer core transforms:
// default sample width, intermediate/output width derivations and Cf.
package dct_pkg;

  localparam int DCT_DW = 25;

  // Rows of Cf, the forward core transform matrix.
  localparam int DCT_CF [4][4] = '{
    '{1,  1,  1,  1},
    '{2,  1, -1, -2},
    '{1, -1, -1,  1},
    '{1, -2,  2, -1}
  };

  // A single 1-D pass has a worst-case gain of 6, so it needs 3 extra bits.
  // Two passes need 6.
  function automatic int dct_iw(input int dw);
    return dw + 3;
  endfunction

  function automatic int dct_ow(input int dw);
    return dw + 6;
  endfunction

endpackage

// File: rtl/dct_1d_4pt.sv
// Combinational 4-point forward core transform (butterfly form).
// Inputs are sign-extended to the output width before any arithmetic.
module dct_1d_4pt #(
  parameter int IN_W  = 25,
  parameter int OUT_W = IN_W + 3
) (
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  input  logic signed [IN_W-1:0]  c,
  input  logic signed [IN_W-1:0]  d,
  output logic signed [OUT_W-1:0] y0,
  output logic signed [OUT_W-1:0] y1,
  output logic signed [OUT_W-1:0] y2,
  output logic signed [OUT_W-1:0] y3
);

  logic signed [OUT_W-1:0] ea, eb, ec, ed;
  logic signed [OUT_W-1:0] s0, s1, d0, d1;

  assign ea = {{(OUT_W-IN_W){a[IN_W-1]}}, a};
  assign eb = {{(OUT_W-IN_W){b[IN_W-1]}}, b};
  assign ec = {{(OUT_W-IN_W){c[IN_W-1]}}, c};
  assign ed = {{(OUT_W-IN_W){d[IN_W-1]}}, d};

  assign s0 = ea + ed;
  assign s1 = eb + ec;
  assign d0 = ea - ed;
  assign d1 = eb - ec;

  assign y0 = s0 + s1;
  assign y1 = (d0 <<< 1) + d1;
  assign y2 = s0 - s1;
  assign y3 = d0 - (d1 <<< 1);

endmodule

// File: rtl/dct_whole.sv
// 4x4 forward integer core transform: row pass into a ping-pong transpose
// buffer, then column pass emitting one coefficient column per cycle.
module dct_whole
  import dct_pkg::*;
#(
  parameter  int DW = DCT_DW,
  localparam int IW = dct_iw(DW),
  localparam int OW = dct_ow(DW)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] d_in_1,
  input  logic signed [DW-1:0] d_in_2,
  input  logic signed [DW-1:0] d_in_3,
  input  logic signed [DW-1:0] d_in_4,
  output logic                 out_valid,
  output logic [1:0]           out_col,
  output logic                 out_last,
  output logic signed [OW-1:0] d_out_1,
  output logic signed [OW-1:0] d_out_2,
  output logic signed [OW-1:0] d_out_3,
  output logic signed [OW-1:0] d_out_4
);

  logic                 accept;
  logic [1:0]           row;
  logic                 wsel;
  logic [1:0]           full, full_nxt;
  logic signed [IW-1:0] t0, t1, t2, t3;
  logic signed [IW-1:0] bank [0:1][0:3][0:3];

  logic                 vld_p0;
  logic [1:0]           col_p0;
  logic                 bank_p0;
  logic                 rd_done, rd_start, bank_nxt;
  logic signed [OW-1:0] y0, y1, y2, y3;

  assign accept = in_valid && !reset;

  // Row pass: T[i][j] for the row currently presented.
  dct_1d_4pt #(.IN_W(DW), .OUT_W(IW)) u_row (
    .a (d_in_1), .b (d_in_2), .c (d_in_3), .d (d_in_4),
    .y0(t0), .y1(t1), .y2(t2), .y3(t3)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      bank[wsel][row][0] <= t0;
      bank[wsel][row][1] <= t1;
      bank[wsel][row][2] <= t2;
      bank[wsel][row][3] <= t3;
    end
  end

  // Reader: walks columns 0..3 of one full bank, then hands over to the
  // other bank on the very next cycle when it is already full.
  always_comb begin
    rd_done  = vld_p0 && (col_p0 == 2'd3);
    bank_nxt = rd_done ? ~bank_p0 : bank_p0;
    rd_start = (!vld_p0 || rd_done) && full[bank_nxt];
    full_nxt = full;
    if (rd_done) full_nxt[bank_p0] = 1'b0;
    if (accept && row == 2'd3) full_nxt[wsel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row     <= 2'd0;
      wsel    <= 1'b0;
      full    <= 2'b00;
      vld_p0  <= 1'b0;
      col_p0  <= 2'd0;
      bank_p0 <= 1'b0;
    end else begin
      full    <= full_nxt;
      bank_p0 <= bank_nxt;
      if (accept) begin
        row <= row + 2'd1;
        if (row == 2'd3) wsel <= ~wsel;
      end
      vld_p0 <= rd_start || (vld_p0 && !rd_done);
      if (rd_start || !vld_p0 || rd_done) col_p0 <= 2'd0;
      else                                col_p0 <= col_p0 + 2'd1;
    end
  end

  // ---- stage p0 -> p1: column pass on the transposed column ----
  dct_1d_4pt #(.IN_W(IW), .OUT_W(OW)) u_col (
    .a (bank[bank_p0][0][col_p0]),
    .b (bank[bank_p0][1][col_p0]),
    .c (bank[bank_p0][2][col_p0]),
    .d (bank[bank_p0][3][col_p0]),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_col   <= 2'd0;
      out_last  <= 1'b0;
      d_out_1   <= '0;
      d_out_2   <= '0;
      d_out_3   <= '0;
      d_out_4   <= '0;
    end else begin
      out_valid <= vld_p0;
      out_col   <= vld_p0 ? col_p0 : 2'd0;
      out_last  <= rd_done;
      if (vld_p0) begin
        d_out_1 <= y0;
        d_out_2 <= y1;
        d_out_3 <= y2;
        d_out_4 <= y3;
      end
    end
  end

endmodule

// File: tb/tb_dct_whole.sv
// Scoreboard bench for dct_whole: a matrix-product reference model queues
// expected columns with their due cycle; a negedge monitor checks them.
module tb_dct_whole;

  localparam int DW = 25;
  localparam int OW = DW + 6;
  localparam longint MAXV = (64'sd1 <<< 24) - 1;
  localparam longint MINV = -(64'sd1 <<< 24);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic signed [DW-1:0] d_in_1, d_in_2, d_in_3, d_in_4;
  logic                 out_valid;
  logic [1:0]           out_col;
  logic                 out_last;
  logic signed [OW-1:0] d_out_1, d_out_2, d_out_3, d_out_4;

  dct_whole #(.DW(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .d_in_1(d_in_1), .d_in_2(d_in_2), .d_in_3(d_in_3), .d_in_4(d_in_4),
    .out_valid(out_valid), .out_col(out_col), .out_last(out_last),
    .d_out_1(d_out_1), .d_out_2(d_out_2), .d_out_3(d_out_3), .d_out_4(d_out_4)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint when;
    int     col;
    longint y0, y1, y2, y3;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad = 0;
  bit     mon_on = 0;
  longint last_y[4];
  int     cf[4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
  longint xrow[4][4];
  int     nrow = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Y = Cf * X * Cf^T by plain matrix products; columns due at N+2..N+5.
  task automatic push_block(input longint n);
    longint t[4][4];
    longint y[4][4];
    exp_t   e;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        t[i][j] = 0;
        for (int k = 0; k < 4; k++) t[i][j] += cf[j][k] * xrow[i][k];
      end
    for (int u = 0; u < 4; u++)
      for (int j = 0; j < 4; j++) begin
        y[u][j] = 0;
        for (int i = 0; i < 4; i++) y[u][j] += cf[u][i] * t[i][j];
      end
    for (int j = 0; j < 4; j++) begin
      e.when = n + 2 + j;
      e.col  = j;
      e.y0 = y[0][j]; e.y1 = y[1][j]; e.y2 = y[2][j]; e.y3 = y[3][j];
      sb.push_back(e);
    end
  endtask

  task automatic send_row(input bit v, input longint x0, input longint x1,
                          input longint x2, input longint x3);
    in_valid = v;
    d_in_1 = x0[DW-1:0]; d_in_2 = x1[DW-1:0];
    d_in_3 = x2[DW-1:0]; d_in_4 = x3[DW-1:0];
    @(posedge clk);
    #1;
    if (v) begin
      xrow[nrow][0] = x0; xrow[nrow][1] = x1; xrow[nrow][2] = x2; xrow[nrow][3] = x3;
      if (nrow == 3) push_block(cyc);
      nrow = (nrow + 1) % 4;
    end
    in_valid = 1'b0;
  endtask

  function automatic longint rnd();
    return longint'($signed($urandom()) >>> 7);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_row(1'b0, rnd(), rnd(), rnd(), rnd());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    d_in_1 = DW'(rnd()); d_in_2 = DW'(rnd()); d_in_3 = DW'(rnd()); d_in_4 = DW'(rnd());
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    nrow = 0;
    for (int i = 0; i < 4; i++) last_y[i] = 0;
  endtask

  task automatic dc_block(input longint v);
    for (int i = 0; i < 4; i++) send_row(1'b1, v, v, v, v);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    idle(2);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_cycle", cyc, e.when);
          check("out_col", longint'(out_col), e.col);
          check("out_last", longint'(out_last), (e.col == 3) ? 1 : 0);
          check("y0", longint'(d_out_1), e.y0);
          check("y1", longint'(d_out_2), e.y1);
          check("y2", longint'(d_out_3), e.y2);
          check("y3", longint'(d_out_4), e.y3);
        end
        last_y[0] = longint'(d_out_1); last_y[1] = longint'(d_out_2);
        last_y[2] = longint'(d_out_3); last_y[3] = longint'(d_out_4);
      end else if (!reset) begin
        check("idle_col", longint'(out_col), 0);
        check("idle_last", longint'(out_last), 0);
        check("hold_y0", longint'(d_out_1), last_y[0]);
        check("hold_y3", longint'(d_out_4), last_y[3]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    d_in_1 = '0; d_in_2 = '0; d_in_3 = '0; d_in_4 = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_d_out_1", longint'(d_out_1), 0);
    mon_on = 1'b1;
    idle(2);

    dc_block(10);
    drain();

    for (int i = 0; i < 4; i++) send_row(1'b1, 1, 0, 0, 0);
    drain();

    dc_block(MINV);
    drain();

    for (int i = 0; i < 4; i++)
      send_row(1'b1, (i % 2) ? -MAXV : MAXV, (i % 2) ? MAXV : -MAXV,
                     (i % 2) ? -MAXV : MAXV, (i % 2) ? MAXV : -MAXV);
    drain();

    dc_block(10);
    dc_block(-3);
    drain();

    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 4; i++) send_row(1'b1, rnd(), rnd(), rnd(), rnd());
    drain();

    for (int i = 0; i < 48; i++) begin
      bit v;
      v = ($urandom_range(0, 2) != 0);
      send_row(v, rnd(), rnd(), rnd(), rnd());
    end
    while (nrow != 0) send_row(1'b1, rnd(), rnd(), rnd(), rnd());
    drain();

    for (int i = 0; i < 3; i++) send_row(1'b1, 7, 7, 7, 7);
    do_reset();
    dc_block(1);
    drain();

    for (int i = 0; i < 4; i++) send_row(1'b1, rnd(), rnd(), rnd(), rnd());
    idle(2);
    do_reset();
    idle(6);
    for (int i = 0; i < 4; i++) send_row(1'b1, rnd(), rnd(), rnd(), rnd());
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
